// File: rtl/mem_req_pkg.sv
// Shared types for the memory request handler:
// FSM states, access sizes, datapath width and alignment helper.
package mem_req_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    case (sz)
      2'd0: bad = 1'b0;
      2'd1: bad = lo[0];
      2'd2: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_request_handler_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and store lane merge.
// Ports: word_i (RAM word), wdata_i, lo_i (addr[1:0]), size_i, uns_i -> load_o, merge_o.
module lane_align
  import mem_req_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      lo_i,
  input  size_e           size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word_i[7:0];
    h       = lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = wdata_i;
    case (lo_i)
      2'd0: b = word_i[7:0];
      2'd1: b = word_i[15:8];
      2'd2: b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{~uns_i & b[7]}}, b};
        merge_o = word_i;
        case (lo_i)
          2'd0: merge_o[7:0]   = wdata_i[7:0];
          2'd1: merge_o[15:8]  = wdata_i[7:0];
          2'd2: merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o  = {{16{~uns_i & h[15]}}, h};
        merge_o = word_i;
        if (lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else         merge_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_request_handler.sv
// Arbitrates CPU fetch / load / store onto a single-port RAM.
// Ports: clk, rst, CPU requests in, instr/d_rdata/resp_valid/d_err/stall out, RAM side.
module mem_request_handler
  import mem_req_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            d_rd,
  input  logic            d_wr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [1:0]      d_size,
  input  logic            d_unsigned,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] d_rdata,
  output logic            resp_valid,
  output logic            d_err,
  output logic            stall,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  output logic            ram_we,
  input  logic [XLEN-1:0] ram_rdata,
  input  logic            ram_busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [XLEN-1:0] la_word;
  logic [XLEN-1:0] la_load;
  logic [XLEN-1:0] la_merge;
  logic            access;

  // Loads align the live RAM word; stores merge into the word read in RMW_RD.
  assign la_word = (state_q == LOAD) ? ram_rdata : word_q;

  lane_align u_lane (
    .word_i  (la_word),
    .wdata_i (wdata_q),
    .lo_i    (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .load_o  (la_load),
    .merge_o (la_merge)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    word_d  = word_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_rd || d_wr) begin
          addr_d  = d_addr;
          wdata_d = d_wdata;
          size_d  = size_e'(d_size);
          uns_d   = d_unsigned;
          err_d   = misaligned(d_size, d_addr[1:0]);
          if (err_d)
            state_d = RESP;
          else if (d_wr)
            state_d = (size_d == SZ_WORD) ? STORE : RMW_RD;
          else
            state_d = LOAD;
        end else if (i_req) begin
          addr_d  = i_addr;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: if (!ram_busy) begin
        instr_d = ram_rdata;
        state_d = RESP;
      end
      LOAD: if (!ram_busy) begin
        rdata_d = la_load;
        state_d = RESP;
      end
      RMW_RD: if (!ram_busy) begin
        word_d  = ram_rdata;
        state_d = STORE;
      end
      STORE: if (!ram_busy) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      word_q  <= word_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

  assign access = (state_q == FETCH) || (state_q == LOAD) ||
                  (state_q == RMW_RD) || (state_q == STORE);

  assign ram_addr   = access ? {addr_q[31:2], 2'b00} : '0;
  assign ram_we     = (state_q == STORE);
  assign ram_wdata  = ram_we ? la_merge : '0;
  assign resp_valid = (state_q == RESP);
  assign d_err      = resp_valid & err_q;
  assign stall      = access ||
                      ((state_q == IDLE) && (i_req || d_rd || d_wr));
  assign instr      = instr_q;
  assign d_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_request_handler.sv
// Scoreboard bench for mem_request_handler with a small behavioural RAM.
// Expected responses are queued at issue and checked on resp_valid.
module tb_mem_request_handler;

  localparam int K_LD = 0;
  localparam int K_ST = 1;
  localparam int K_IF = 2;
  localparam int K_ER = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          idx;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] instr;
  logic [31:0] d_rdata;
  logic        resp_valid;
  logic        d_err;
  logic        stall;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  logic [31:0] mem [0:63];
  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  logic        watch = 1'b0;
  logic        bad_acc = 1'b0;
  int          n;

  mem_request_handler dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .instr      (instr),
    .d_rdata    (d_rdata),
    .resp_valid (resp_valid),
    .d_err      (d_err),
    .stall      (stall),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .ram_busy   (ram_busy)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk)
    if (ram_we && !ram_busy) mem[ram_addr[7:2]] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v,
                      input int idx, input string tag);
    exp_t x;
    x.kind = k;
    x.val  = v;
    x.idx  = idx;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && ram_we) begin
      we_cnt++;
      last_wd = ram_wdata;
    end
    if (!rst && watch && (ram_we || ram_addr != 0)) bad_acc = 1'b1;
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_LD: begin
            chk({e.tag, "_err"}, {31'd0, d_err}, 32'd0);
            chk({e.tag, "_rdata"}, d_rdata, e.val);
          end
          K_ST: begin
            chk({e.tag, "_err"}, {31'd0, d_err}, 32'd0);
            chk({e.tag, "_mem"}, mem[e.idx], e.val);
          end
          K_IF: chk({e.tag, "_instr"}, instr, e.val);
          default: begin
            chk({e.tag, "_err"}, {31'd0, d_err}, 32'd1);
            chk({e.tag, "_rdata"}, d_rdata, e.val);
          end
        endcase
      end
    end
  end

  // Drive one request, optionally hold ram_busy nb cycles, check latency.
  task automatic issue(input logic ir, input logic [31:0] ia,
                       input logic rd, input logic wr,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un,
                       input int nb, input int lat, input string tag);
    int c;
    i_req = ir; i_addr = ia;
    d_rd = rd; d_wr = wr; d_addr = da;
    d_wdata = wd; d_size = sz; d_unsigned = un;
    #1;
    chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    c = 1;
    i_req = ir & (rd | wr);
    d_rd = 1'b0; d_wr = 1'b0;
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h5A5A_5A5A; d_size = 2'd3;
    ram_busy = (nb > 0);
    while (!resp_valid && c < 20) begin
      @(negedge clk);
      c++;
      if (c > nb) ram_busy = 1'b0;
    end
    ram_busy = 1'b0;
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h80FF_FFFF;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'hDEAD_BEEF;
    mem[4] = 32'h0000_0013;
    mem[5] = 32'hCAFE_F00D;
    mem[6] = 32'h0BAD_F00D;
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0;
    d_addr = 0; d_wdata = 0; d_size = 0; d_unsigned = 0;
    ram_busy = 0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rdata", d_rdata, 32'd0);
    chk("rst_ctrl", {27'd0, resp_valid, d_err, stall, ram_we, 1'b0},
        32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    rst = 1'b0;

    push(K_LD, 32'hDEAD_BEEF, 0, "ld_word");
    issue(0, 0, 1, 0, 32'h8, 0, 2'd2, 0, 0, 2, "ld_word");

    we_cnt = 0;
    push(K_ST, 32'h1122_AA44, 1, "st_byte");
    issue(0, 0, 0, 1, 32'h5, 32'h1234_56AA, 2'd0, 0, 0, 3, "st_byte");
    chk("st_byte_we_cnt", we_cnt, 1);
    chk("st_byte_wdata", last_wd, 32'h1122_AA44);

    push(K_LD, 32'hFFFF_FF80, 0, "ld_sb");
    issue(0, 0, 1, 0, 32'h3, 0, 2'd0, 0, 0, 2, "ld_sb");
    push(K_LD, 32'h0000_0080, 0, "ld_ub");
    issue(0, 0, 1, 0, 32'h3, 0, 2'd0, 1, 0, 2, "ld_ub");

    watch = 1'b1; bad_acc = 1'b0;
    push(K_ER, 32'h0000_0080, 0, "mis_half");
    issue(0, 0, 1, 0, 32'h3, 0, 2'd1, 0, 0, 1, "mis_half");
    watch = 1'b0;
    chk("mis_half_noram", {31'd0, bad_acc}, 32'd0);

    push(K_ST, 32'h0BAD_F00D, 6, "st_word");
    issue(0, 0, 0, 1, 32'h18, 32'h0BAD_F00D, 2'd2, 0, 0, 2, "st_word");

    push(K_ST, 32'h5678_AA44, 1, "st_half");
    issue(0, 0, 0, 1, 32'h6, 32'hABCD_5678, 2'd1, 0, 0, 3, "st_half");

    push(K_LD, 32'hFFFF_FFFF, 0, "ld_sh");
    issue(0, 0, 1, 0, 32'h0, 0, 2'd1, 0, 0, 2, "ld_sh");

    push(K_ER, 32'hFFFF_FFFF, 0, "sz3");
    issue(0, 0, 1, 0, 32'h0, 0, 2'd3, 0, 0, 1, "sz3");

    push(K_ST, 32'h1234_5678, 7, "rdwr");
    issue(0, 0, 1, 1, 32'h1C, 32'h1234_5678, 2'd2, 0, 0, 2, "rdwr");

    push(K_LD, 32'hDEAD_BEEF, 0, "combo_ld");
    push(K_IF, 32'h0000_0013, 0, "combo_if");
    issue(1, 32'h10, 1, 0, 32'h8, 0, 2'd2, 0, 3, 5, "combo");
    chk("combo_gap_stall", {31'd0, stall}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) i_req = 1'b0;
    end while (!resp_valid && n < 10);
    chk("combo_if_lat", n, 2);
    @(negedge clk);

    push(K_IF, 32'hCAFE_F00D, 0, "fetch");
    issue(1, 32'h14, 0, 0, 0, 0, 2'd0, 0, 0, 2, "fetch");

    we_cnt = 0;
    push(K_ST, 32'hEEAD_F00D, 6, "st_busy");
    issue(0, 0, 0, 1, 32'h1B, 32'h0000_00EE, 2'd0, 0, 2, 5, "st_busy");
    chk("st_busy_we_cnt", we_cnt, 1);

    d_wr = 1; d_addr = 32'h20; d_wdata = 32'h55; d_size = 2'd2;
    @(negedge clk);
    d_wr = 0;
    ram_busy = 1'b1;
    chk("rst_mid_we_pre", {31'd0, ram_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we", {31'd0, ram_we}, 32'd0);
    chk("rst_mid_ctrl", {28'd0, resp_valid, d_err, stall, ram_we},
        32'd0);
    chk("rst_mid_addr", ram_addr, 32'd0);
    chk("rst_mid_wdata", ram_wdata, 32'd0);
    chk("rst_mid_rdata", d_rdata, 32'd0);
    chk("rst_mid_instr", instr, 32'd0);
    @(negedge clk);
    ram_busy = 1'b0;
    rst = 1'b0;
    chk("rst_mid_nowrite", mem[8], 32'd0);

    push(K_LD, 32'hDEAD_BEEF, 0, "post_rst");
    issue(0, 0, 1, 0, 32'h8, 0, 2'd2, 0, 0, 2, "post_rst");

    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_request_handler.md
MEM_REQUEST_HANDLER -- requirements
Module: mem_request_handler

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have ports i_req in 1, i_addr in 32: instruction fetch request and byte address.
REQ-004 SHALL have ports d_rd in 1, d_wr in 1, d_addr in 32, d_wdata in 32, d_size in 2 (0 byte, 1 half, 2 word), d_unsigned in 1: data load/store request.
REQ-005 SHALL have outputs instr out 32, d_rdata out 32, resp_valid out 1, d_err out 1, stall out 1: CPU-side results and freeze.
REQ-006 SHALL have RAM-side ports ram_addr out 32, ram_wdata out 32, ram_we out 1, ram_rdata in 32 (combinational read of word at ram_addr), ram_busy in 1.

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, LOAD, RMW_RD, STORE, RESP.
REQ-008 IDLE SHALL sample requests each edge; d_rd/d_wr take priority over i_req; d_rd and d_wr both high -> treated as store.
REQ-009 Transitions SHALL be: IDLE->LOAD (d_rd); IDLE->STORE (d_wr, size word); IDLE->RMW_RD (d_wr, byte/half); IDLE->FETCH (i_req only); LOAD/FETCH/STORE->RESP; RMW_RD->STORE; RESP->IDLE.
REQ-010 Request fields SHALL be registered on IDLE exit; CPU inputs are ignored until RESP.
REQ-011 ram_addr SHALL equal {registered addr[31:2], 2'b00} in FETCH, LOAD, RMW_RD, STORE; 0 in IDLE/RESP.
REQ-012 ram_we SHALL be 1 only in STORE; ram_wdata SHALL be 0 outside STORE.
REQ-013 Any access state with ram_busy=1 SHALL hold state, outputs, and not capture ram_rdata.
REQ-014 FETCH SHALL capture ram_rdata into instr; LOAD SHALL capture the lane selected by addr[1:0] into d_rdata, zero-extended if d_unsigned else sign-extended.
REQ-015 RMW_RD SHALL capture the old word; STORE SHALL write it with the addressed byte (d_wdata[7:0]) or half (d_wdata[15:0]) lane replaced; word store writes d_wdata unchanged.
REQ-016 Misaligned data request (half with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->RESP directly, no RAM access, d_err=1 in RESP, d_rdata unchanged.
REQ-017 d_size=3 SHALL be treated as misaligned (d_err).
REQ-018 resp_valid SHALL be 1 exactly during RESP; d_err SHALL be 0 outside RESP.
REQ-019 stall SHALL be 1 when state is not IDLE/RESP, or in IDLE with any request asserted; 0 otherwise.
REQ-020 Unloaded latency SHALL be: fetch/load/word store 2 cycles to resp_valid, byte/half store 3 cycles, plus one per ram_busy cycle.
REQ-021 Fetch behind a data request SHALL be serviced in a separate transaction after RESP->IDLE while i_req is held.

Reset
REQ-022 rst SHALL force state IDLE and instr, d_rdata, captured word, registered request fields to 0 immediately, including mid-access; ram_we SHALL drop to 0 without waiting for a clock.
REQ-023 After rst deasserts, first request SHALL be accepted on the first rising edge.

Structure
REQ-024 Shared package mem_req_pkg SHALL hold the state enum, the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), and width constant XLEN=32.
REQ-025 Lane extract/sign-extend/merge SHALL be one combinational sub-module lane_align, instantiated once.

Verification
REQ-026 Word load d_addr=0x8, RAM word2=0xDEADBEEF, no busy -> resp_valid two cycles later, d_rdata=0xDEADBEEF, stall high for two cycles.
REQ-027 Byte store d_addr=0x5 data 0xAA over word1=0x11223344 -> RMW_RD then STORE, ram_wdata=0x1122AA44, ram_we one cycle, resp at cycle 3.
REQ-028 Signed byte load addr 0x3 of 0x80FFFFFF -> d_rdata=0xFFFFFF80; same with d_unsigned=1 -> 0x00000080.
REQ-029 i_req and d_rd together -> LOAD then RESP, then FETCH, instr valid in second RESP; ram_busy high 3 cycles in LOAD -> resp delayed exactly 3 cycles.
REQ-030 Half load d_addr=0x3 -> resp_valid after one cycle with d_err=1, ram_addr never nonzero, ram_we never 1.
REQ-031 rst asserted during STORE with ram_busy=1 -> ram_we=0 same cycle, state IDLE, all outputs 0.
